uart_tx_line_arbiter: RTL and testbench
=======================================

// Module: uart_tx_line_arbiter
// PURPOSE
//   Shares one UART transmit serializer between NUM_REQ byte producers (per-hart console ports).
//   Grant is line-locked: the owner keeps the serializer until it sends '\n', hits MAX_LINE bytes
//   or goes idle for IDLE_TIMEOUT cycles, so lines never interleave. Optional per-line tag "<id>:".
//   Sits between core console FIFOs and the UART TX serializer, whose frame is 1 start, 8 data LSB-first, 1 stop.
// PARAMETERS
//   NUM_REQ       4     requesters, 1..10 (tag digit is '0'+id)
//   MAX_LINE      255   bytes per grant before forced release (1..255)
//   IDLE_TIMEOUT  1024  cycles of owner valid low before forced release (>=2)
//   TAG_EN        1     1: emit id tag + ':' before first byte of each grant
// PORTS
//   clk_i         in   1             clock
//   rst_ni        in   1             async reset, active low
//   req_valid_i   in   NUM_REQ       requester byte valid
//   req_data_i    in   NUM_REQ*8     requester bytes, req i at [8*i +: 8]
//   req_ready_o   out  NUM_REQ       byte accepted when valid&ready
//   tx_valid_o    out  1             byte to serializer valid
//   tx_data_o     out  8             byte to serializer
//   tx_ready_i    in   1             serializer accepts byte
//   owner_o       out  clog2(NUM_REQ) current/last grant index
//   busy_o        out  1             state != IDLE
//   timeout_o     out  1             1-cycle pulse on idle-timeout release
// BEHAVIOUR
//   Reset: state=IDLE, tx_valid_o=0, tx_data_o=0, req_ready_o=0, owner_o=0,
//     rr pointer=0, byte count=0, idle count=0, busy_o=0, timeout_o=0.
//   FSM IDLE -> (TAG_ID -> TAG_SEP if TAG_EN) -> STREAM -> IDLE.
//   IDLE: if any req_valid_i, grant first valid index at or after rr pointer (wrapping);
//     register owner; next state TAG_ID (TAG_EN) else STREAM. No grant if none valid.
//   TAG_ID: tx_valid_o=1, tx_data_o="0"+owner; on tx_ready_i -> TAG_SEP.
//   TAG_SEP: tx_valid_o=1, tx_data_o=":"; on tx_ready_i -> STREAM. Tag bytes not counted.
//   STREAM: combinational pass-through: tx_valid_o=req_valid_i[owner],
//     tx_data_o=req_data_i[owner], req_ready_o[owner]=tx_ready_i; all other req_ready_o=0.
//   req_ready_o is 0 in IDLE/TAG states; non-owners never see ready.
//   Byte count +1 per accepted owner byte (8-bit, saturating; never wraps).
//   Release (-> IDLE, rr pointer=owner+1 mod NUM_REQ, count=0) when, in STREAM:
//     accepted byte == 8'h0A; or accepted byte makes count == MAX_LINE;
//     or idle count reaches IDLE_TIMEOUT (timeout_o pulses that cycle).
//   Idle count: +1 each STREAM cycle with owner valid low; cleared on owner valid high or release.
//   '\n' and MAX_LINE on same byte: single release, no extra effect.
//   Release cycle is non-grant; earliest next tag/byte one cycle after return to IDLE.
//   tx_valid_o, once high, holds with stable tx_data_o until tx_ready_i (TAG states by design;
//     STREAM relies on requester valid/data being stable until ready).
//   Single requester: still releases per line, re-tags every line.
//   owner_o holds last owner in IDLE. Async reset mid-line: all state cleared immediately,
//     any partial line is dropped from the arbiter's view (serializer handles its own reset).
// TESTING
//   TAG_EN=1, req0 sends "hi\n", tx_ready_i=1 -> tx bytes '0',':','h','i',0x0A; then IDLE; rr=1.
//   req0,req2 both valid at reset release -> req0 line fully sent before any '2' tag byte; then req2.
//   req1 sends 300 bytes, no '\n', MAX_LINE=255 -> release after byte 255; re-tag "1:", 45 bytes follow.
//   req3 sends "ab" then valid low 1024 cycles -> timeout_o pulses once, busy_o=0 next cycle.
//   tx_ready_i low 10 cycles during TAG_SEP -> tx_valid_o=1, tx_data_o=':' stable throughout.
//   rst_ni low mid-STREAM -> all outputs at reset values same cycle (async); after release, fresh arbitration from idx 0.

Source files
------------

// File: rtl/uart_tx_line_arbiter.sv
// Line-locked arbiter that shares one UART TX serializer between NUM_REQ
// console byte producers. A grant holds until '\n', MAX_LINE bytes, or
// IDLE_TIMEOUT idle cycles, so lines from different harts never interleave.
// Each grant can be prefixed with an "<id>:" tag.
`timescale 1ns/1ps
module uart_tx_line_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_LINE     = 255,
  parameter int IDLE_TIMEOUT = 1024,
  parameter int TAG_EN       = 1,
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int IW = $clog2(IDLE_TIMEOUT + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 tx_valid_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_ready_i,
  output logic [OW-1:0]        owner_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  typedef enum logic [1:0] {S_IDLE, S_TAG_ID, S_TAG_SEP, S_STREAM} state_e;

  state_e        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] rr_q, rr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [IW-1:0] idle_q, idle_d;

  logic          gnt_found;
  logic [OW-1:0] gnt_idx;
  logic          own_vld;
  logic [7:0]    own_data;
  logic          accept;
  logic          release_line;
  logic [7:0]    cnt_inc;
  logic [IW-1:0] idle_inc;

  // Index base+k wrapped into 0..NUM_REQ-1 (k < NUM_REQ, base < NUM_REQ).
  function automatic logic [OW-1:0] wrap_idx(input logic [OW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return OW'(s);
  endfunction

  // Round-robin pick: first valid requester at or after the rr pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && req_valid_i[wrap_idx(rr_q, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_idx(rr_q, k);
      end
    end
  end

  assign own_vld  = req_valid_i[owner_q];
  assign own_data = req_data_i[8*owner_q +: 8];
  assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign idle_inc = idle_q + 1'b1;

  // Next-state, datapath muxing and release decisions.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    idle_d       = idle_q;
    tx_valid_o   = 1'b0;
    tx_data_o    = 8'h00;
    req_ready_o  = '0;
    timeout_o    = 1'b0;
    accept       = 1'b0;
    release_line = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          owner_d = gnt_idx;
          cnt_d   = 8'd0;
          idle_d  = '0;
          state_d = (TAG_EN != 0) ? S_TAG_ID : S_STREAM;
        end
      end
      S_TAG_ID: begin
        tx_valid_o = 1'b1;
        tx_data_o  = 8'h30 + 8'(owner_q);
        if (tx_ready_i) state_d = S_TAG_SEP;
      end
      S_TAG_SEP: begin
        tx_valid_o = 1'b1;
        tx_data_o  = 8'h3A;
        if (tx_ready_i) state_d = S_STREAM;
      end
      S_STREAM: begin
        tx_valid_o           = own_vld;
        tx_data_o            = own_data;
        req_ready_o[owner_q] = tx_ready_i;
        accept               = own_vld & tx_ready_i;
        idle_d               = own_vld ? '0 : idle_inc;
        if (accept) begin
          cnt_d = cnt_inc;
          if (own_data == 8'h0A || cnt_inc == 8'(MAX_LINE)) release_line = 1'b1;
        end
        // A requester that falls silent mid-line must not hold the UART forever.
        if (!own_vld && idle_inc == IW'(IDLE_TIMEOUT)) begin
          release_line = 1'b1;
          timeout_o    = 1'b1;
        end
        if (release_line) begin
          state_d = S_IDLE;
          rr_d    = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
          cnt_d   = 8'd0;
          idle_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops any partial line immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= 8'd0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
    end
  end

  assign busy_o  = (state_q != S_IDLE);
  assign owner_o = owner_q;

endmodule

// File: tb/tb_uart_tx_line_arbiter.sv
// Directed bench for uart_tx_line_arbiter: requester byte streams are loaded
// into per-port buffers, the expected serializer byte order goes into a queue
// and is checked on every tx handshake.
`timescale 1ns/1ps
module tb_uart_tx_line_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [1:0]  owner;
  logic        busy;
  logic        timeout;

  int errors = 0;
  int checks = 0;
  int tocnt  = 0;

  logic [7:0] sbuf [4][512];
  int         sptr [4];
  int         slen [4];
  logic [7:0] expq [$];

  always #5 clk = ~clk;

  uart_tx_line_arbiter #(
    .NUM_REQ(4), .MAX_LINE(255), .IDLE_TIMEOUT(1024), .TAG_EN(1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_ready_o(req_ready),
    .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_ready_i(tx_ready),
    .owner_o(owner), .busy_o(busy), .timeout_o(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < 4; i++) begin
      sptr[i] = 0;
      slen[i] = 0;
    end
  endtask

  task automatic load_str(input int r, input string s);
    for (int i = 0; i < s.len(); i++) begin
      sbuf[r][slen[r]] = s[i];
      slen[r] = slen[r] + 1;
    end
  endtask

  task automatic exp_str(input string s);
    for (int i = 0; i < s.len(); i++) expq.push_back(s[i]);
  endtask

  task automatic exp_tag(input int r);
    expq.push_back(8'(8'h30 + r));
    expq.push_back(8'h3A);
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = (sptr[i] < slen[i]);
      req_data[8*i +: 8] = (sptr[i] < slen[i]) ? sbuf[i][sptr[i]] : 8'h00;
    end
  endtask

  // One clock: drive, sample at negedge, advance past the posedge.
  task automatic cyc();
    logic [7:0] e;
    drive_reqs();
    @(negedge clk);
    if (tx_valid && tx_ready) begin
      if (expq.size() == 0) begin
        checks++;
        assert (expq.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_tx: observed %0h expected no byte", tx_data);
        end
      end else begin
        e = expq.pop_front();
        chk("tx_byte", {24'h0, tx_data}, {24'h0, e});
      end
    end
    chk("nonowner_ready", {28'h0, req_ready & ~(4'b0001 << owner)}, 32'h0);
    for (int i = 0; i < 4; i++)
      if (req_valid[i] && req_ready[i]) sptr[i] = sptr[i] + 1;
    if (timeout) tocnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int maxc);
    int n = 0;
    while (expq.size() != 0 && n < maxc) begin
      cyc();
      n++;
    end
    chk({tag, "_drain"}, expq.size(), 0);
  endtask

  task automatic wait_timeout(input string tag);
    int n = 0;
    int t0 = tocnt;
    while (tocnt == t0 && n < 1100) begin
      cyc();
      n++;
    end
    chk({tag, "_to_cycles"}, n, 1024);
    chk({tag, "_busy_after_to"}, {31'h0, busy}, 0);
    cyc();
    chk({tag, "_to_once"}, tocnt - t0, 1);
  endtask

  initial begin
    req_valid = '0;
    req_data  = '0;
    tx_ready  = 1'b1;
    clear_src();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_valid", {31'h0, tx_valid}, 0);
    chk("rst_tx_data", {24'h0, tx_data}, 0);
    chk("rst_req_ready", {28'h0, req_ready}, 0);
    chk("rst_owner", {30'h0, owner}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_timeout", {31'h0, timeout}, 0);
    rst_n = 1'b1;

    // "hi\n" from req0 with tag
    load_str(0, "hi\n");
    exp_tag(0); exp_str("hi\n");
    drain("t1", 20);
    chk("t1_busy", {31'h0, busy}, 0);
    chk("t1_owner", {30'h0, owner}, 0);

    // rr pointer now 1: req2 wins over req0
    load_str(0, "x\n");
    load_str(2, "y\n");
    exp_tag(2); exp_str("y\n");
    exp_tag(0); exp_str("x\n");
    drain("t1b", 30);

    // req0 and req2 valid across reset release: req0 line completes first
    rst_n = 1'b0;
    clear_src();
    load_str(0, "A\n");
    load_str(2, "B\n");
    drive_reqs();
    @(posedge clk);
    #1;
    chk("t2_rst_ready", {28'h0, req_ready}, 0);
    chk("t2_rst_valid", {31'h0, tx_valid}, 0);
    rst_n = 1'b1;
    exp_tag(0); exp_str("A\n");
    exp_tag(2); exp_str("B\n");
    drain("t2", 30);

    // 300 bytes with no newline from req1: split after 255
    clear_src();
    for (int i = 0; i < 300; i++) begin
      sbuf[1][i] = 8'(8'h41 + (i % 26));
      expq.push_back(8'(8'h41 + (i % 26)));
      if (i == 0)   begin expq.pop_back(); exp_tag(1); expq.push_back(8'h41); end
      if (i == 254) exp_tag(1);
    end
    slen[1] = 300;
    drain("t3", 400);
    chk("t3_busy_open_line", {31'h0, busy}, 1);
    wait_timeout("t3");

    // req3 "ab" then silence: idle timeout release
    clear_src();
    load_str(3, "ab");
    exp_tag(3); exp_str("ab");
    drain("t4", 20);
    wait_timeout("t4");

    // serializer stall during the ':' byte
    clear_src();
    load_str(2, "z\n");
    exp_tag(2); exp_str("z\n");
    cyc();
    cyc();
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t5_stall_valid", {31'h0, tx_valid}, 1);
      chk("t5_stall_data", {24'h0, tx_data}, 32'h3A);
    end
    tx_ready = 1'b1;
    drain("t5", 20);

    // asynchronous reset in the middle of a line
    clear_src();
    load_str(1, "abcdef\n");
    exp_tag(1); exp_str("ab");
    drain("t6_pre", 20);
    drive_reqs();
    #1;
    chk("t6_busy_pre", {31'h0, busy}, 1);
    chk("t6_valid_pre", {31'h0, tx_valid}, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_tx_valid", {31'h0, tx_valid}, 0);
    chk("t6_tx_data", {24'h0, tx_data}, 0);
    chk("t6_req_ready", {28'h0, req_ready}, 0);
    chk("t6_owner", {30'h0, owner}, 0);
    chk("t6_busy", {31'h0, busy}, 0);
    chk("t6_timeout", {31'h0, timeout}, 0);
    clear_src();
    drive_reqs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    load_str(0, "p\n");
    load_str(3, "q\n");
    exp_tag(0); exp_str("p\n");
    exp_tag(3); exp_str("q\n");
    drain("t6", 30);
    chk("t6_busy_end", {31'h0, busy}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
